// File: rtl/shift_arbiter_ctrl.sv
// Two-port shift request arbiter feeding one shared 32-bit shifter (SLL/SRL/SRA).
// Results are registered and held under resp_valid/resp_ready backpressure.
module shift_arbiter_ctrl #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [4:0]  req0_shamt,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [4:0]  req1_shamt,
  output logic        req1_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_id,
  output logic        resp_err,
  output logic        busy,
  output logic        dbg_state_o
);

  // Handshake: a transfer on port N happens on a rising edge where reqN_valid
  // and reqN_ready are both 1; a result leaves when resp_valid and resp_ready are both 1.
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_id_q;
  logic        resp_err_q, resp_err_d;

  logic        window;
  logic        grant;
  logic        xfer;
  logic [1:0]  sel_op;
  logic [31:0] sel_a;
  logic [4:0]  sel_shamt;

  always_comb begin
    state_d     = state_q;
    grant       = 1'b0;
    resp_data_d = 32'h0;
    resp_err_d  = 1'b0;

    window = !reset && ((state_q == IDLE) || resp_ready);

    // Contended requests go to the port that did not win last, or port 0 in fixed mode.
    if (req0_valid && req1_valid) begin
      grant = FAIR ? ~last_grant_q : 1'b0;
    end else begin
      grant = req1_valid;
    end

    req0_ready = window && req0_valid && !grant;
    req1_ready = window && req1_valid && grant;
    xfer       = req0_ready || req1_ready;

    sel_op    = grant ? req1_op    : req0_op;
    sel_a     = grant ? req1_a     : req0_a;
    sel_shamt = grant ? req1_shamt : req0_shamt;

    case (sel_op)
      2'b00:   resp_data_d = sel_a << sel_shamt;
      2'b01:   resp_data_d = sel_a >> sel_shamt;
      2'b10:   resp_data_d = $signed(sel_a) >>> sel_shamt;
      default: begin
        resp_data_d = 32'h0;
        resp_err_d  = 1'b1;
      end
    endcase

    case (state_q)
      IDLE:    if (xfer) state_d = RESP;
      RESP:    if (resp_ready && !xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      resp_data_q  <= 32'h0;
      resp_id_q    <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        last_grant_q <= grant;
        resp_data_q  <= resp_data_d;
        resp_id_q    <= grant;
        resp_err_q   <= resp_err_d;
      end
    end
  end

  assign resp_valid  = (state_q == RESP);
  assign busy        = resp_valid;
  assign resp_data   = resp_data_q;
  assign resp_id     = resp_id_q;
  assign resp_err    = resp_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// Directed bench for shift_arbiter_ctrl: a driver pushes expected results into a
// queue, a negedge monitor compares every presented response against its head.
module tb_shift_arbiter_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [1:0]  req0_op = 2'b00, req1_op = 2'b00;
  logic [31:0] req0_a = 32'h0, req1_a = 32'h0;
  logic [4:0]  req0_shamt = 5'd0, req1_shamt = 5'd0;
  logic        resp_ready = 1'b0;

  logic        req0_ready, req1_ready, resp_valid, resp_id, resp_err, busy, dbg_state;
  logic [31:0] resp_data;
  logic        fx_req0_ready, fx_req1_ready, fx_resp_valid, fx_resp_id, fx_resp_err;
  logic        fx_busy, fx_dbg_state;
  logic [31:0] fx_resp_data;

  logic [33:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  shift_arbiter_ctrl #(.FAIR(1'b1)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a),
    .req0_shamt(req0_shamt), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a),
    .req1_shamt(req1_shamt), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .resp_err(resp_err), .busy(busy), .dbg_state_o(dbg_state)
  );

  shift_arbiter_ctrl #(.FAIR(1'b0)) u_fix (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a),
    .req0_shamt(req0_shamt), .req0_ready(fx_req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a),
    .req1_shamt(req1_shamt), .req1_ready(fx_req1_ready),
    .resp_valid(fx_resp_valid), .resp_ready(resp_ready), .resp_data(fx_resp_data),
    .resp_id(fx_resp_id), .resp_err(fx_resp_err), .busy(fx_busy), .dbg_state_o(fx_dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; e0/e1 are the hand-computed readies, ed/ee the result of the accepted request.
  task automatic step(input logic v0, input logic [1:0] o0, input logic [31:0] a0,
                      input logic [4:0] s0, input logic v1, input logic [1:0] o1,
                      input logic [31:0] a1, input logic [4:0] s1, input logic rr,
                      input logic e0, input logic e1, input logic [31:0] ed,
                      input logic ee, input logic fchk);
    @(posedge clock); #1;
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_shamt = s0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_shamt = s1;
    resp_ready = rr;
    #1;
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    if (fchk) begin
      chk("fixed_req0_ready", fx_req0_ready, 1'b1);
      chk("fixed_req1_ready", fx_req1_ready, 1'b0);
    end
    if (e0 || e1) exp_q.push_back({e1, ee, ed});
  endtask

  task automatic idle(input logic rr);
    step(0, 2'b00, 32'h0, 5'd0, 0, 2'b00, 32'h0, 5'd0, rr, 0, 0, 32'h0, 0, 0);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=%h required=none", {resp_id, resp_err, resp_data});
      end else begin
        chk("resp", {resp_id, resp_err, resp_data}, exp_q[0]);
        chk("busy", busy, 1'b1);
        if (resp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    // reset: valid requests must not be accepted
    repeat (2) @(posedge clock);
    #1;
    req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
    #1;
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    @(posedge clock); #1;
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_id", resp_id, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_state", dbg_state, 1'b0);
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

    // first request: SRA sign fill, 1-cycle latency
    step(1, 2'b10, 32'h8000_0000, 5'd4, 0, 2'b00, 32'h0, 5'd0, 1, 1, 0, 32'hF800_0000, 0, 0);
    // contended stream, alternating grants, boundaries
    step(1, 2'b00, 32'h1, 5'd31, 1, 2'b01, 32'hFFFF_FFFF, 5'd31, 1, 0, 1, 32'h0000_0001, 0, 0);
    step(1, 2'b00, 32'h1, 5'd31, 1, 2'b10, 32'h7FFF_FFFF, 5'd31, 1, 1, 0, 32'h8000_0000, 0, 0);
    step(1, 2'b11, 32'h1234, 5'd3, 1, 2'b10, 32'h7FFF_FFFF, 5'd31, 1, 0, 1, 32'h0, 0, 0);
    step(1, 2'b11, 32'h1234, 5'd3, 1, 2'b00, 32'hDEAD_BEEF, 5'd0, 1, 1, 0, 32'h0, 1, 0);
    // backpressure: hold 3 cycles, then accept on release
    step(0, 2'b00, 32'h0, 5'd0, 1, 2'b00, 32'hDEAD_BEEF, 5'd0, 1, 0, 1, 32'hDEAD_BEEF, 0, 0);
    repeat (3)
      step(1, 2'b01, 32'h8000_0000, 5'd0, 1, 2'b10, 32'h8000_0000, 5'd0, 0, 0, 0, 32'h0, 0, 0);
    step(1, 2'b01, 32'h8000_0000, 5'd0, 1, 2'b10, 32'h8000_0000, 5'd0, 1, 1, 0, 32'h8000_0000, 0, 0);
    step(0, 2'b00, 32'h0, 5'd0, 1, 2'b10, 32'h8000_0000, 5'd0, 1, 0, 1, 32'h8000_0000, 0, 0);
    idle(0);

    // reset while a result is held: it is discarded
    @(posedge clock); #1;
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b0;
    #1;
    chk("rstp_req0_ready", req0_ready, 1'b0);
    chk("rstp_req1_ready", req1_ready, 1'b0);
    @(posedge clock); #1;
    exp_q.delete();
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rstp_resp_valid", resp_valid, 1'b0);
    chk("rstp_busy", busy, 1'b0);

    // after reset, port 0 wins the first contended grant
    step(1, 2'b00, 32'h3, 5'd4, 1, 2'b01, 32'h0F00, 5'd8, 1, 1, 0, 32'h30, 0, 0);
    step(1, 2'b10, 32'hF000_0000, 5'd28, 1, 2'b01, 32'h0F00, 5'd8, 1, 0, 1, 32'hF, 0, 0);
    step(1, 2'b10, 32'hF000_0000, 5'd28, 0, 2'b00, 32'h0, 5'd0, 1, 1, 0, 32'hFFFF_FFFF, 0, 0);
    idle(1);

    // fixed priority instance always grants port 0; fair instance keeps alternating
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        step(1, 2'b00, 32'h1, 5'd1, 1, 2'b01, 32'h8, 5'd1, 1, 0, 1, 32'h4, 0, 1);
      else
        step(1, 2'b00, 32'h1, 5'd1, 1, 2'b01, 32'h8, 5'd1, 1, 1, 0, 32'h2, 0, 1);
    end

    // drain
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      idle(1);
    end
    idle(1);
    chk("drain_queue_empty", exp_q.size(), 34'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_arbiter_ctrl.md
SHIFT_ARBITER_CTRL -- requirements
Module: shift_arbiter_ctrl

Interface
REQ-001 Parameter FAIR, default 1, arbitration mode: 1 = round-robin between ports, 0 = fixed priority to port 0.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 req0_valid / req1_valid  input  1  port N presents a shift request.
REQ-005 req0_op / req1_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
REQ-006 req0_a / req1_a  input  32  operand to shift.
REQ-007 req0_shamt / req1_shamt  input  5  shift amount, 0..31.
REQ-008 req0_ready / req1_ready  output  1  controller accepts port N this cycle.
REQ-009 resp_valid  output  1  registered result available.
REQ-010 resp_ready  input  1  consumer accepts the result this cycle.
REQ-011 resp_data  output  32  shift result.
REQ-012 resp_id  output  1  port number whose request produced resp_data.
REQ-013 resp_err  output  1  request carried reserved op 11.
REQ-014 busy  output  1  equals resp_valid.

Function
REQ-015 The block SHALL own one shared 32-bit shifter datapath (SLL, SRL, SRA) and serialise both ports onto it.
REQ-016 FSM SHALL have two states: IDLE (no result held) and RESP (result held, resp_valid=1).
REQ-017 Acceptance window SHALL be open when state==IDLE, or when state==RESP and resp_ready==1.
REQ-018 With the window open, exactly one reqN_ready SHALL be 1: the granted port, and only if that port's valid is 1. Otherwise both readies SHALL be 0.
REQ-019 Grant, one port valid: that port.
REQ-020 Grant, both valid, FAIR=1: the port other than last_grant. FAIR=0: port 0.
REQ-021 last_grant SHALL update to the accepted port on every transfer (valid and ready both 1) and SHALL be unchanged otherwise.
REQ-022 A transfer SHALL be captured on the clock edge. On the next cycle the FSM SHALL be in RESP with resp_data, resp_id and resp_err registered. Latency is 1 cycle.
REQ-023 In RESP with resp_ready=1 and a new transfer in the same cycle, the FSM SHALL stay in RESP and load the new result. Throughput is 1 result per cycle.
REQ-024 In RESP with resp_ready=1 and no transfer, the FSM SHALL go to IDLE.
REQ-025 In RESP with resp_ready=0, resp_data, resp_id and resp_err SHALL hold stable, and both readies SHALL be 0.
REQ-026 SLL and SRL SHALL zero-fill. SRA SHALL fill with a[31].
REQ-027 shamt=0 SHALL pass the operand through unchanged for every valid op.
REQ-028 Op 11 SHALL complete the handshake normally with resp_err=1 and resp_data=0x0000_0000.
REQ-029 Requesters SHALL hold their request fields stable until accepted. The controller does not check this.
REQ-030 In IDLE, resp_data, resp_id and resp_err SHALL retain their last values. Consumers SHALL ignore them while resp_valid=0.

Reset
REQ-031 While reset=1 at a clock edge: state SHALL go to IDLE, resp_valid=0, busy=0, resp_data=0, resp_id=0, resp_err=0, and last_grant=1 so port 0 wins the first contended grant.
REQ-032 While reset=1, both reqN_ready SHALL be 0 and no transfer SHALL occur.
REQ-033 Reset asserted in RESP SHALL discard the held result with no response delivered.

Verification
REQ-034 After reset, port 0 SRA a=0x8000_0000 shamt=4, resp_ready=1 -> req0_ready=1 in the same cycle. Next cycle: resp_valid=1, resp_data=0xF800_0000, resp_id=0, resp_err=0.
REQ-035 FAIR=1, both ports valid continuously, resp_ready=1 -> grants alternate 0,1,0,1 starting with port 0, and resp_valid stays 1 every cycle after the first.
REQ-036 Backpressure: result held with resp_ready=0 for 3 cycles -> resp_data and resp_id stable, both readies 0. Raising resp_ready -> handshake completes and the next request is accepted in that same cycle.
REQ-037 Boundaries: SLL 0x1 shamt 31 -> 0x8000_0000; SRL 0xFFFF_FFFF shamt 31 -> 0x0000_0001; SRA 0x7FFF_FFFF shamt 31 -> 0x0; shamt 0 -> operand unchanged; op 11 -> resp_err=1, resp_data=0.
REQ-038 Reset pulsed while in RESP with resp_ready=0 -> resp_valid=0 the cycle after reset. With both ports then valid, port 0 is granted first.
REQ-039 FAIR=0, both ports valid for 4 cycles -> port 0 granted every cycle and req1_ready held 0.
